// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Optional perf counters are enabled with IFU_PERF_CNT_EN.
package ifu_pkg;

    localparam logic [1:0]  PCSRC_SEQ  = 2'd0;
    localparam logic [1:0]  PCSRC_JUMP = 2'd1;
    localparam logic [1:0]  PCSRC_JR   = 2'd2;
    localparam logic [31:0] WORD_INC   = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FLUSH
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ifu_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Instruction queue: synchronous FIFO of {pc, word} entries.
// Clear has priority over push/pop in the same cycle.
module ifu_inst_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [63:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_cnt == CW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign head      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, queue, redirects.
// Define IFU_PERF_CNT_EN to add perf_fetched/perf_flushed counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Instruction,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic [31:0] inst_pc,
    input  logic        resolve_valid,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e    r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [63:0]   w_head;
    ifu_entry_t    w_head_e;
    logic [CW:0]   w_used;
    logic          w_accept;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_redirect;
    logic [31:0]   w_target;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_resp_pc;

    assign w_used = {1'b0, r_out} + {1'b0, w_count};
    assign imem_req_valid = (r_state == S_FETCH)
                          && (w_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_accept   = imem_req_valid && imem_req_ready;
    assign w_resp     = imem_resp_valid && (r_out != '0);
    assign w_out_next = r_out + CW'(w_accept) - CW'(w_resp);
    // Oldest in-flight request sits outstanding words behind the PC.
    assign w_resp_pc  = r_pc - (32'(r_out) << 2);

    assign w_push = (r_state == S_FETCH) && w_resp && !w_redirect
                  && (!w_full || w_pop);
    assign w_pop  = inst_valid && inst_ready && !w_redirect;

    assign w_head_e    = w_head;
    assign inst_valid  = !w_empty;
    assign Instruction = w_empty ? 32'd0 : w_head_e.word;
    assign inst_pc     = w_empty ? 32'd0 : w_head_e.pc;
    assign OpCode      = Instruction[31:26];
    assign Funct       = Instruction[5:0];

    // Decode the resolved control-flow outcome; PCSrc 3 acts as sequential.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = branch_target;
        if (resolve_valid) begin
            unique case (PCSrc)
                PCSRC_JUMP: begin
                    w_redirect = 1'b1;
                    w_target   = jump_target;
                end
                PCSRC_JR: begin
                    w_redirect = 1'b1;
                    w_target   = jr_target;
                end
                default: begin
                    w_redirect = Branch && Zero;
                    w_target   = branch_target;
                end
            endcase
        end
    end

    ifu_inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (w_push),
        .push_data({w_resp_pc, imem_resp_data}),
        .pop      (w_pop),
        .clear    (w_redirect),
        .head     (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    // PC, credit tracking and boot/fetch/flush sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
        end else begin
            r_out <= w_out_next;
            if (w_redirect) begin
                r_pc <= align_word(w_target);
            end else if (w_accept) begin
                r_pc <= r_pc + WORD_INC;
            end
            if (w_redirect) begin
                r_drop  <= w_out_next;
                r_state <= (w_out_next != '0) ? S_FLUSH : S_FETCH;
            end else begin
                unique case (r_state)
                    S_BOOT: r_state <= S_FETCH;
                    S_FLUSH: begin
                        if (w_resp) begin
                            r_drop <= r_drop - CW'(1);
                            if (r_drop == CW'(1)) r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic        w_drop_resp;
    logic [31:0] w_cleared;

    assign w_drop_resp = w_resp && ((r_state == S_FLUSH)
                       || ((r_state == S_FETCH) && w_redirect));
    assign w_cleared   = w_redirect ? 32'(w_count) : 32'd0;

    // Count pushed words and words discarded by redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(w_push);
            perf_flushed <= perf_flushed + w_cleared + 32'(w_drop_resp);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit with an in-order memory model
// and an expected-PC-stream reference.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] inst_pc;
    logic        resolve_valid;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .Instruction    (Instruction),
        .OpCode         (OpCode),
        .Funct          (Funct),
        .inst_pc        (inst_pc),
        .resolve_valid  (resolve_valid),
        .PCSrc          (PCSrc),
        .Branch         (Branch),
        .Zero           (Zero),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .jr_target      (jr_target)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_q [$];
    int          mem_t [$];
    int          cyc = 0;
    int          mem_budget = -1;
    bit          rnd_mode = 0;
    bit          rdy_on = 1;

    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          n_req;
    int          n_pop;
    logic [31:0] last_req_addr;
    logic [31:0] last_pop_pc;
    bit          s_req_valid;
    bit          s_inst_valid;
    bit          saw_zero_req;

    logic        d_rv = 0;
    logic [1:0]  d_pcsrc = 0;
    logic        d_branch = 0;
    logic        d_zero = 0;
    logic [31:0] d_btgt = 0;
    logic [31:0] d_jtgt = 0;
    logic [31:0] d_jrtgt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        if ($urandom_range(0, 7) == 0)
            return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return RESET_PC + 32'($urandom_range(0, 1023));
    endfunction

    // Taken-redirect rule straight from the control-flow definition.
    function automatic logic taken_f(input logic rv, input logic [1:0] s,
                                     input logic b, input logic z);
        if (!rv) return 1'b0;
        if (s == 2'd1 || s == 2'd2) return 1'b1;
        return b && z;
    endfunction

    task automatic cycle();
        logic        tk;
        logic [31:0] tg;
        logic [31:0] w;
        @(negedge clk);
        if (rnd_mode) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d_rv     = 1'b1;
                d_pcsrc  = 2'($urandom_range(0, 3));
                d_branch = 1'($urandom_range(0, 1));
                d_zero   = 1'($urandom_range(0, 1));
                d_btgt   = rnd_tgt();
                d_jtgt   = rnd_tgt();
                d_jrtgt  = rnd_tgt();
            end
        end else begin
            imem_req_ready = 1'b1;
            inst_ready     = rdy_on && !d_rv;
        end
        resolve_valid = d_rv;
        PCSrc         = d_pcsrc;
        Branch        = d_branch;
        Zero          = d_zero;
        branch_target = d_btgt;
        jump_target   = d_jtgt;
        jr_target     = d_jrtgt;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        if (mem_q.size() > 0 && mem_t[0] <= cyc && mem_budget != 0
            && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0]);
            void'(mem_q.pop_front());
            void'(mem_t.pop_front());
            if (mem_budget > 0) mem_budget--;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_inst_valid = inst_valid;
        tk = taken_f(d_rv, d_pcsrc, d_branch, d_zero);
        tg = (d_pcsrc == 2'd1) ? d_jtgt :
             (d_pcsrc == 2'd2) ? d_jrtgt : d_btgt;
        tg = {tg[31:2], 2'b00};
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req);
            mem_q.push_back(imem_req_addr);
            mem_t.push_back(cyc + 1);
            exp_req       = exp_req + 32'd4;
            last_req_addr = imem_req_addr;
            if (imem_req_addr == 32'd0) saw_zero_req = 1'b1;
            n_req++;
        end
        check("credit", 32'(mem_q.size() <= FIFO_DEPTH), 32'd1);
        if (inst_valid && inst_ready && !tk) begin
            w = mem_word(exp_pc);
            check("inst_pc", inst_pc, exp_pc);
            check("instr", Instruction, w);
            check("opcode", 32'(OpCode), 32'(w[31:26]));
            check("funct", 32'(Funct), 32'(w[5:0]));
            last_pop_pc = inst_pc;
            exp_pc      = exp_pc + 32'd4;
            n_pop++;
        end
        if (tk) begin
            exp_pc  = tg;
            exp_req = tg;
        end
        d_rv = 1'b0;
        cyc++;
    endtask

    task automatic resolve(input logic [1:0] s, input logic b,
                           input logic z, input logic [31:0] t);
        d_rv     = 1'b1;
        d_pcsrc  = s;
        d_branch = b;
        d_zero   = z;
        d_btgt   = (s == 2'd0) ? t : 32'h0040_0F00;
        d_jtgt   = (s == 2'd1) ? t : 32'h0040_0E00;
        d_jrtgt  = (s == 2'd2) ? t : 32'h0040_0D00;
        cycle();
    endtask

    task automatic wait_pop(input string tag, input int lim);
        int n0 = n_pop;
        for (int i = 0; i < lim && n_pop == n0; i++) cycle();
        if (n_pop == n0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string tag, input int lim);
        int n0 = n_req;
        for (int i = 0; i < lim && n_req == n0; i++) cycle();
        if (n_req == n0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        inst_ready = 0; resolve_valid = 0; PCSrc = 0; Branch = 0; Zero = 0;
        branch_target = 0; jump_target = 0; jr_target = 0;
        mem_q.delete();
        mem_t.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        @(negedge clk);
        reset   = 1'b1;
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
        n_req   = 0;
        n_pop   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int p;
        logic [31:0] pf0;
        c0 = -1;
        c1 = -1;
        pf0 = 0;
        p = 0;
        saw_zero_req = 0;
        do_reset();

        rnd_mode = 0; rdy_on = 1; mem_budget = -1;
        for (int i = 0; i < 10 && !s_req_valid; i++) cycle();
        if (s_req_valid) c0 = cyc - 1;
        check("first_req_addr", last_req_addr, RESET_PC);
        for (int i = 0; i < 10 && !s_inst_valid; i++) cycle();
        if (s_inst_valid) c1 = cyc - 1;
        check("first_valid_latency", 32'(c1 - c0), 32'd2);
        repeat (6) cycle();

        rdy_on = 0;
        repeat (10) cycle();
        check("stall_in_unit", 32'(n_req - n_pop), 32'(FIFO_DEPTH));
        check("stall_no_req", 32'(s_req_valid), 32'd0);
        rdy_on = 1;
        repeat (10) cycle();

        mem_budget = 0;
        repeat (8) cycle();
        check("hold_inflight", 32'(mem_q.size()), 32'(FIFO_DEPTH));
        check("hold_queue_empty", 32'(s_inst_valid), 32'd0);
`ifdef IFU_PERF_CNT_EN
        pf0 = perf_flushed;
`endif
        resolve(2'd0, 1'b1, 1'b1, 32'h0040_0040);
        mem_budget = -1;
        wait_pop("beq_taken", 40);
        check("beq_taken_pc", last_pop_pc, 32'h0040_0040);
`ifdef IFU_PERF_CNT_EN
        check("perf_flushed_beq", perf_flushed - pf0, 32'(FIFO_DEPTH));
`endif
        repeat (4) cycle();

        p = n_pop;
        pf0 = last_pop_pc;
        resolve(2'd0, 1'b1, 1'b0, 32'h0040_0800);
        if (n_pop == p) wait_pop("beq_not_taken", 40);
        check("beq_not_taken_pc", last_pop_pc, pf0 + 32'd4);

        resolve(2'd2, 1'b0, 1'b0, 32'h0040_0102);
        wait_req("jr", 40);
        check("jr_aligned_addr", last_req_addr, 32'h0040_0100);
        repeat (6) cycle();

        mem_budget = 0;
        repeat (8) cycle();
`ifdef IFU_PERF_CNT_EN
        pf0 = perf_flushed;
`endif
        resolve(2'd2, 1'b0, 1'b0, 32'h0040_0300);
        mem_budget = FIFO_DEPTH - 1;
        for (int i = 0; i < 20 && mem_q.size() > 1; i++) cycle();
        check("flush_one_left", 32'(mem_q.size()), 32'd1);
        resolve(2'd1, 1'b0, 1'b0, 32'h0040_0200);
        mem_budget = -1;
        wait_req("flush_redirect", 40);
        check("flush_redirect_addr", last_req_addr, 32'h0040_0200);
        wait_pop("flush_redirect_pop", 40);
        check("flush_redirect_pc", last_pop_pc, 32'h0040_0200);
`ifdef IFU_PERF_CNT_EN
        check("perf_flushed_flush", perf_flushed - pf0, 32'(FIFO_DEPTH));
`endif

        resolve(2'd2, 1'b0, 1'b0, 32'hFFFF_FFF8);
        for (int i = 0; i < 30 && !saw_zero_req; i++) cycle();
        check("pc_wrap", 32'(saw_zero_req), 32'd1);
        repeat (6) cycle();

        rnd_mode = 1;
        repeat (2000) cycle();
        rnd_mode = 0;
        rdy_on = 1;
        mem_budget = -1;
        wait_pop("drain", 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
